// File: rtl/pipe_skid_reg.sv
// Purpose : inter-stage pipeline register with a two-entry skid buffer; payload plus write enables.
// Latency : 1 cycle input-to-output when empty; sustains 1 slot/cycle with out_ready high.
// Backpressure: in_ready is registered (= !s_valid); skid entry absorbs the slot in flight during a stall.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   flush                synchronous squash of both held entries; same-cycle input dropped
//   in_valid/in_ready    upstream handshake; in_data/in_we upstream payload and write enables
//   out_valid/out_ready  downstream handshake; out_data/out_we from the main entry (0 when !out_valid)
//   occupancy            number of held entries, 0..2
//   stall_cnt            (only with PIPE_STALL_STAT_EN) saturating count of out_valid & !out_ready cycles
//
// Optional feature macro: PIPE_STALL_STAT_EN
module pipe_skid_reg #(
    parameter int DATA_W = 64,
    parameter int NUM_WE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NUM_WE-1:0] in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_WE-1:0] out_we,
`ifdef PIPE_STALL_STAT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [1:0]        occupancy
);

    // Main entry drives the outputs; skid entry catches the slot accepted while main is stalled.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [NUM_WE-1:0] m_we;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [NUM_WE-1:0] s_we;

    logic in_fire;
    logic out_fire;
    logic m_free;

    // in_ready comes straight from a flop, so upstream never sees a combinational path from out_ready.
    assign in_ready  = ~s_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;
    assign m_free    = ~m_valid | out_fire;

    // Empty entries are always held at zero, so the main entry can drive the outputs directly.
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_we    = m_we;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_we    <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_we    <= '0;
        end else if (flush) begin
            // Squash both entries; any slot offered this cycle is dropped.
            m_valid <= 1'b0;
            m_data  <= '0;
            m_we    <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_we    <= '0;
        end else if (m_free) begin
            if (s_valid) begin
                // Drain the older skid slot first to keep FIFO order; in_fire cannot coincide.
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_we    <= s_we;
                s_valid <= 1'b0;
                s_data  <= '0;
                s_we    <= '0;
            end else if (in_fire) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_we    <= in_we;
            end else begin
                // Bubble: zero payload so a non-valid slot can never carry write enables.
                m_valid <= 1'b0;
                m_data  <= '0;
                m_we    <= '0;
            end
        end else if (in_fire) begin
            // Main is stalled: park the incoming slot in the skid entry.
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_we    <= in_we;
        end
    end

`ifdef PIPE_STALL_STAT_EN
    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (m_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;
    localparam int DATA_W = 64;
    localparam int NUM_WE = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [NUM_WE-1:0] in_we;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [NUM_WE-1:0] out_we;
    logic [1:0]        occupancy;
`ifdef PIPE_STALL_STAT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries: {data, we}
    logic [DATA_W+NUM_WE-1:0] exp_q[$];

    pipe_skid_reg #(.DATA_W(DATA_W), .NUM_WE(NUM_WE)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_we    (out_we),
`ifdef PIPE_STALL_STAT_EN
        .stall_cnt (stall_cnt),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus helper: advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a slot; the expected output is queued when the bench will see it accepted.
    task automatic offer(input logic [DATA_W-1:0] d, input logic [NUM_WE-1:0] w);
        in_valid = 1'b1;
        in_data  = d;
        in_we    = w;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (!out_valid) begin
                check("idle_data_zero", out_data, 0);
                check("idle_we_zero", out_we, 0);
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got data 0x%0h we 0x%0h expected no slot", out_data, out_we);
                end else begin
                    check("out_slot", {out_data, out_we}, exp_q.pop_front());
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back({in_data, in_we});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_we     = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occupancy", occupancy, 0);
        rst = 1'b0;
        step();

        // Streaming 1..4 at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(i, 4'b0001);
            step();
            check("stream_in_ready", in_ready, 1);
            check("stream_occ", occupancy, 1);
            check("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_occ", occupancy, 0);

        // Stall / skid
        out_ready = 1'b0;
        offer(64'h11, 4'b0011);
        step();
        offer(64'h22, 4'b0110);
        step();
        in_valid = 1'b0;
        check("skid_occ", occupancy, 2);
        check("skid_in_ready", in_ready, 0);
        check("skid_out_data", out_data, 64'h11);
        out_ready = 1'b1;
        step();
        check("skid_release_in_ready", in_ready, 1);
        check("skid_release_data", out_data, 64'h22);
        check("skid_release_occ", occupancy, 1);
        step();
        check("skid_drain_occ", occupancy, 0);

        // Flush at full occupancy
        out_ready = 1'b0;
        offer(64'h33, 4'b1111);
        step();
        offer(64'h44, 4'b1111);
        step();
        check("flush_pre_occ", occupancy, 2);
        flush = 1'b1;
        offer(64'h55, 4'b1111);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_we", out_we, 4'b0000);
        check("flush_occ", occupancy, 0);
        check("flush_in_ready", in_ready, 1);

        // Flush at occupancy 1 with an accepted input: that input must vanish
        offer(64'h66, 4'b1111);
        step();
        flush = 1'b1;
        offer(64'h77, 4'b1111);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush1_occ", occupancy, 0);
        check("flush1_out_valid", out_valid, 0);
        step();
        check("flush1_after_occ", occupancy, 0);

        // Bubble
        offer(64'hAB, 4'b0101);
        step();
        in_valid = 1'b0;
        check("bubble_valid", out_valid, 1);
        check("bubble_data", out_data, 64'hAB);
        check("bubble_we", out_we, 4'b0101);
        step();
        check("bubble_after_valid", out_valid, 0);
        check("bubble_after_data", out_data, 0);
        check("bubble_after_we", out_we, 0);

        // Reset mid-transfer at occupancy 2
        out_ready = 1'b0;
        offer(64'h88, 4'b1001);
        step();
        offer(64'h99, 4'b1010);
        step();
        in_valid = 1'b0;
        check("rstmid_pre_occ", occupancy, 2);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_we", out_we, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_occ", occupancy, 0);
        step();
        rst = 1'b0;
        step();
        check("rstmid_after_occ", occupancy, 0);

`ifdef PIPE_STALL_STAT_EN
        check("stat_after_rst", stall_cnt, 0);
        out_ready = 1'b0;
        offer(64'hC0, 4'b0001);
        step();
        in_valid = 1'b0;
        check("stat_start", stall_cnt, 0);
        for (int i = 0; i < 10; i++) step();
        check("stat_ten", stall_cnt, 10);
        for (int i = 0; i < 70000; i++) step();
        check("stat_sat", stall_cnt, 16'hFFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("stat_flush_keep", stall_cnt, 16'hFFFF);
        rst = 1'b1;
        #1;
        check("stat_rst_clear", stall_cnt, 0);
        step();
        rst = 1'b0;
        step();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W payload and NUM_WE write-enable bits between two stages over a valid/ready handshake.
- A two-entry skid buffer sustains one transfer per cycle with registered in_ready.
- Flush and bubble handling force all write enables low, so a squashed slot can never write architectural state.

Parameters:
DATA_W, 64, payload width in bits (addresses, data, HI/LO, CP0 fields packed by instantiator)
NUM_WE, 4, number of write-enable bits (reg, HI/LO, LLbit, CP0); forced to 0 in any non-valid slot

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held entries (exception/eret)
in_valid  in  1  upstream stage presents a slot
in_ready  out  1  this block can accept a slot; registered, equals !skid_valid
in_data  in  DATA_W  upstream payload
in_we  in  NUM_WE  upstream write enables
out_valid  out  1  downstream slot valid
out_ready  in  1  downstream stage accepts slot (0 = stall)
out_data  out  DATA_W  payload of main entry; 0 when !out_valid
out_we  out  NUM_WE  write enables of main entry; 0 when !out_valid
occupancy  out  2  held entries, 0..2

Behaviour:
- Storage: main entry (m_valid, m_data, m_we) drives outputs directly; skid entry (s_valid, s_data, s_we) is internal.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (async, rst=1): m_valid=s_valid=0, all data/we regs=0. Outputs: out_valid=0, out_data=0, out_we=0, in_ready=1, occupancy=0. Reset mid-transfer discards both entries.
- Priority at each clock edge: reset > flush > normal update.
- Flush=1 clears both entries to zero. Any in_fire in the same cycle is dropped. Next cycle: in_ready=1, occupancy=0, out_we=0.
- Normal update when the main entry is free (!m_valid or out_fire):
  - s_valid: main<=skid, s_valid<=0.
  - else in_fire: main<=input.
  - else: m_valid<=0, m_data<=0, m_we<=0 (bubble).
- Normal update when the main entry is held (m_valid & !out_fire):
  - in_fire: skid<=input, s_valid<=1.
  - main is unchanged.
- Cannot occur: s_valid=1 together with in_fire (in_ready=0).
- Latency: in_fire at edge N gives out_valid at N+1 when empty. Throughput is 1 slot/cycle with out_ready held high.
- Full (occupancy=2): in_ready=0 until the cycle after out_fire.
- Simultaneous in_fire and out_fire at occupancy=1: main replaced by input, occupancy stays 1.
- Ordering is strictly FIFO; no slot is duplicated or lost except by flush/reset.
- occupancy = m_valid + s_valid, registered.
- Invariant: any stored entry with valid=0 holds data=0, we=0.

Optional Feature:
PIPE_STALL_STAT_EN
- Defined: adds output stall_cnt (16 bits), counting cycles with out_valid & !out_ready. Saturates at 16'hFFFF. Cleared by rst only; flush does not clear it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset: rst=1 mid-transfer with occupancy=2 -> immediately out_valid=0, out_we=0, in_ready=1, occupancy=0.
2. Streaming: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, in_ready stays 1, occupancy=1.
3. Stall/skid: hold out_ready=0 while sending A=0x11, B=0x22 -> occupancy=2, in_ready=0, out_data=0x11. Release out_ready -> 0x11 then 0x22, and in_ready=1 the cycle after the first out_fire.
4. Flush: occupancy=2 with in_we=4'b1111, assert flush with in_valid=1 -> next cycle out_valid=0, out_we=4'b0000, occupancy=0, and the flush-cycle input never appears.
5. Bubble: single slot 0xAB with we=4'b0101, then in_valid=0 -> out_valid=1 for one cycle, then out_data=0, out_we=0.
6. PIPE_STALL_STAT_EN: out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF. Flush -> count retained. rst -> 0.
